// File: rtl/gray_sweep_controller.sv
// Binary/Gray sweep sequencer: steps a counter up or down and streams
// each word with its Gray encoding over a valid/ready output.
module gray_sweep_controller #(
    parameter int WIDTH = 3,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_cont,
    input  logic             dir_down,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        GAP_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1 = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cont_q, cont_d;
    logic             down_q, down_d;
    logic             valid_q, busy_q, done_q;
    logic             terminal;

    assign terminal = down_q ? (bin_q == '0) : (bin_q == ALL1);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        cont_d  = cont_q;
        down_d  = down_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cont_d  = mode_cont;
                    down_d  = dir_down;
                    bin_d   = dir_down ? ALL1 : '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // A handshake coinciding with stop is delivered; nothing follows.
                if (stop) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (terminal && !cont_q) begin
                        state_d = DONE;
                    end else begin
                        bin_d   = down_q ? bin_q - ONE : bin_q + ONE;
                        cnt_d   = GAP_LOAD;
                        state_d = (GAP > 0) ? GAP_WAIT : EMIT;
                    end
                end
            end
            GAP_WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= bin_d ^ (bin_d >> 1);
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            down_q  <= down_d;
            valid_q <= (state_d == EMIT);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign out_valid = valid_q;
    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gray_sweep_controller.sv
// Directed bench for gray_sweep_controller: vector table plus
// hand-written gap and asynchronous-reset sequences.
module tb_gray_sweep_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       g_start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic       dir_down = 1'b0;
    logic       out_ready = 1'b0;

    logic       out_valid, busy, done;
    logic [2:0] bin_out, gray_out;
    logic       g_valid, g_busy, g_done;
    logic [2:0] g_bin, g_gray;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_sweep_controller #(.WIDTH(3), .GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mode_cont(mode_cont), .dir_down(dir_down),
        .out_ready(out_ready), .out_valid(out_valid),
        .bin_out(bin_out), .gray_out(gray_out),
        .busy(busy), .done(done)
    );

    gray_sweep_controller #(.WIDTH(3), .GAP(2)) u_gap (
        .clk(clk), .rst_n(rst_n), .start(g_start), .stop(stop),
        .mode_cont(mode_cont), .dir_down(dir_down),
        .out_ready(out_ready), .out_valid(g_valid),
        .bin_out(g_bin), .gray_out(g_gray),
        .busy(g_busy), .done(g_done)
    );

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       cont;
        logic       down;
        logic       ready;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [8:0] pk(logic v, logic [2:0] b,
                                      logic [2:0] g, logic bs, logic d);
        return {v, b, g, bs, d};
    endfunction

    task automatic add(logic s, logic p, logic c, logic d, logic r,
                       logic v, logic [2:0] b, logic [2:0] g,
                       logic bs, logic dn);
        vec_t t;
        t.start = s;
        t.stop  = p;
        t.cont  = c;
        t.down  = d;
        t.ready = r;
        t.exp   = pk(v, b, g, bs, dn);
        tbl.push_back(t);
    endtask

    task automatic check(string name, logic [8:0] got, logic [8:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {v,bin,gray,busy,done}=%b want %b",
                     name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // sweep up, single, back-to-back
        add(1,0,0,0,1, 1,3'd0,3'b000,1,0);
        add(0,0,0,0,1, 1,3'd1,3'b001,1,0);
        add(0,0,0,0,1, 1,3'd2,3'b011,1,0);
        add(0,0,0,0,1, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,1, 1,3'd4,3'b110,1,0);
        add(0,0,0,0,1, 1,3'd5,3'b111,1,0);
        add(0,0,0,0,1, 1,3'd6,3'b101,1,0);
        add(0,0,0,0,1, 1,3'd7,3'b100,1,0);
        add(0,0,0,0,1, 0,3'd7,3'b100,1,1);
        add(0,0,0,0,1, 0,3'd7,3'b100,0,0);
        // backpressure on word 3
        add(1,0,0,0,1, 1,3'd0,3'b000,1,0);
        add(0,0,0,0,1, 1,3'd1,3'b001,1,0);
        add(0,0,0,0,1, 1,3'd2,3'b011,1,0);
        add(0,0,0,0,1, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,0, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,0, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,0, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,1, 1,3'd4,3'b110,1,0);
        add(0,1,0,0,0, 0,3'd4,3'b110,0,0);
        // down, continuous; mode/dir inputs flipped mid-sweep
        add(1,0,1,1,1, 1,3'd7,3'b100,1,0);
        add(0,0,0,0,1, 1,3'd6,3'b101,1,0);
        add(0,0,0,0,1, 1,3'd5,3'b111,1,0);
        add(0,0,0,0,1, 1,3'd4,3'b110,1,0);
        add(0,0,0,0,1, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,1, 1,3'd2,3'b011,1,0);
        add(0,0,0,0,1, 1,3'd1,3'b001,1,0);
        add(0,0,0,0,1, 1,3'd0,3'b000,1,0);
        add(0,0,0,0,1, 1,3'd7,3'b100,1,0);
        add(0,0,0,0,1, 1,3'd6,3'b101,1,0);
        add(0,1,0,0,1, 0,3'd6,3'b101,0,0);
        // stop while word 5 accepted; start ignored while busy
        add(1,0,0,0,1, 1,3'd0,3'b000,1,0);
        add(0,0,0,0,1, 1,3'd1,3'b001,1,0);
        add(1,0,0,0,1, 1,3'd2,3'b011,1,0);
        add(0,0,0,0,1, 1,3'd3,3'b010,1,0);
        add(0,0,0,0,1, 1,3'd4,3'b110,1,0);
        add(0,0,0,0,1, 1,3'd5,3'b111,1,0);
        add(0,1,0,0,1, 0,3'd5,3'b111,0,0);
        add(1,1,0,0,1, 0,3'd5,3'b111,0,0);
        add(1,0,0,0,1, 1,3'd0,3'b000,1,0);
        add(0,1,0,0,1, 0,3'd0,3'b000,0,0);

        #3;
        check("reset", {out_valid, bin_out, gray_out, busy, done}, 9'd0);
        check("reset_gap", {g_valid, g_bin, g_gray, g_busy, g_done}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            start     = tbl[i].start;
            stop      = tbl[i].stop;
            mode_cont = tbl[i].cont;
            dir_down  = tbl[i].down;
            out_ready = tbl[i].ready;
            step();
            check($sformatf("vec%0d", i),
                  {out_valid, bin_out, gray_out, busy, done}, tbl[i].exp);
        end
        start = 1'b0;
        stop  = 1'b0;

        // GAP=2 single sweep: valid pattern 1,0,0 per word
        begin
            logic [2:0] gr [8];
            gr[0] = 3'b000; gr[1] = 3'b001; gr[2] = 3'b011; gr[3] = 3'b010;
            gr[4] = 3'b110; gr[5] = 3'b111; gr[6] = 3'b101; gr[7] = 3'b100;
            mode_cont = 1'b0;
            dir_down  = 1'b0;
            out_ready = 1'b1;
            g_start   = 1'b1;
            step();
            g_start = 1'b0;
            for (int w = 0; w < 8; w++) begin
                check($sformatf("gap_word%0d", w),
                      {g_valid, g_bin, g_gray, g_busy, g_done},
                      pk(1'b1, 3'(w), gr[w], 1'b1, 1'b0));
                step();
                if (w < 7) begin
                    check($sformatf("gap_idle%0da", w),
                          {g_valid, g_bin, g_gray, g_busy, g_done},
                          pk(1'b0, 3'(w + 1), gr[w + 1], 1'b1, 1'b0));
                    step();
                    check($sformatf("gap_idle%0db", w),
                          {g_valid, g_bin, g_gray, g_busy, g_done},
                          pk(1'b0, 3'(w + 1), gr[w + 1], 1'b1, 1'b0));
                    step();
                end
            end
            check("gap_done", {g_valid, g_bin, g_gray, g_busy, g_done},
                  pk(1'b0, 3'd7, 3'b100, 1'b1, 1'b1));
            step();
            check("gap_idle", {g_valid, g_bin, g_gray, g_busy, g_done},
                  pk(1'b0, 3'd7, 3'b100, 1'b0, 1'b0));
        end

        // asynchronous reset between edges, mid-sweep
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst", {out_valid, bin_out, gray_out, busy, done},
              pk(1'b1, 3'd2, 3'b011, 1'b1, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", {out_valid, bin_out, gray_out, busy, done}, 9'd0);
        check("async_rst_gap", {g_valid, g_bin, g_gray, g_busy, g_done}, 9'd0);
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_start", {out_valid, bin_out, gray_out, busy, done},
              pk(1'b1, 3'd0, 3'b000, 1'b1, 1'b0));
        step();
        check("post_rst_next", {out_valid, bin_out, gray_out, busy, done},
              pk(1'b1, 3'd1, 3'b001, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
